// File: rtl/dpc_pkg.sv
// Shared types and helpers for the defect-pixel-correction LUT path: FSM states and the
// packed {y, x} LUT word layout.
package dpc_pkg;

    localparam int unsigned Y_LSB = 16;
    localparam int unsigned X_LSB = 0;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2
    } cal_state_e;

    function automatic logic [31:0] pack_bad_xy(input logic [15:0] y, input logic [15:0] x);
        logic [31:0] w_word;
        w_word = '0;
        w_word[Y_LSB +: 16] = y;
        w_word[X_LSB +: 16] = x;
        return w_word;
    endfunction

endpackage

// File: rtl/badpoint_order_filter.sv
// Raster-order gate for LUT candidates: remembers the last written key and decides whether a
// new flagged pixel is written, dropped as a duplicate, or dropped as out-of-order.
module badpoint_order_filter #(
    parameter int unsigned KEY_BITS = 20
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_cand,
    input  logic [KEY_BITS-1:0] i_key,
    input  logic                i_full,
    output logic                o_write,
    output logic                o_order_err,
    output logic                o_overflow
);

    logic                r_last_valid;
    logic [KEY_BITS-1:0] r_last_key;
    logic                w_last_ok;
    logic                w_newer;

    // i_clear lets the first pixel of a new frame bypass the previous frame's last key
    assign w_last_ok   = r_last_valid & ~i_clear;
    assign w_newer     = ~w_last_ok | (i_key > r_last_key);
    assign o_order_err = i_cand & w_last_ok & (i_key < r_last_key);
    assign o_write     = i_cand & w_newer & ~i_full;
    assign o_overflow  = i_cand & w_newer & i_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_valid <= 1'b0;
            r_last_key   <= '0;
        end else if (o_write) begin
            r_last_valid <= 1'b1;
            r_last_key   <= i_key;
        end else if (i_clear) begin
            r_last_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/badpoint_lut_capture.sv
// Calibration capture: records flagged pixel coordinates of one armed frame into the bad-pixel
// LUT in ascending raster order and commits the entry count at frame end.
module badpoint_lut_capture
    import dpc_pkg::*;
#(
    parameter int unsigned WIDTH_BITS    = 10,
    parameter int unsigned HEIGHT_BITS   = 10,
    parameter int unsigned BAD_POINT_NUM = 128,
    parameter int unsigned BAD_POINT_BIT = 7
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cal_start,
    input  logic                     i_frame_start,
    input  logic                     i_frame_end,
    input  logic                     i_s_valid,
    input  logic [WIDTH_BITS-1:0]    i_s_x,
    input  logic [HEIGHT_BITS-1:0]   i_s_y,
    input  logic                     i_s_flag,
    output logic                     o_wen_lut,
    output logic [BAD_POINT_BIT-1:0] o_waddr_lut,
    output logic [31:0]              o_wdata_lut,
    output logic [BAD_POINT_BIT-1:0] o_bad_point_num,
    output logic                     o_cal_busy,
    output logic                     o_cal_done,
    output logic                     o_overflow,
    output logic                     o_order_err
);

    localparam int unsigned KEY_BITS = HEIGHT_BITS + WIDTH_BITS;
    localparam logic [BAD_POINT_BIT-1:0] PTR_MAX = BAD_POINT_BIT'(BAD_POINT_NUM - 1);

    cal_state_e               r_state;
    cal_state_e               w_state_next;
    logic                     w_restart;
    logic                     w_capturing;
    logic                     w_commit;
    logic                     w_cand;
    logic                     w_write;
    logic                     w_order_hit;
    logic                     w_ovf_hit;
    logic                     w_full;
    logic [KEY_BITS-1:0]      w_key;
    logic [BAD_POINT_BIT-1:0] r_ptr;
    logic [BAD_POINT_BIT-1:0] w_ptr_eff;
    logic [BAD_POINT_BIT-1:0] w_ptr_next;
    logic                     r_wen;
    logic [BAD_POINT_BIT-1:0] r_waddr;
    logic [31:0]              r_wdata;
    logic [BAD_POINT_BIT-1:0] r_num;
    logic                     r_done;
    logic                     r_overflow;
    logic                     r_order_err;

    // A frame_start seen in capture means frame_end went missing: commit, and skip that pixel
    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_capturing  = 1'b0;
        w_commit     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_cal_start) begin
                    w_state_next = StArmed;
                end
            end
            StArmed: begin
                if (i_frame_start) begin
                    w_state_next = StCapture;
                    w_restart    = 1'b1;
                    w_capturing  = 1'b1;
                end
            end
            StCapture: begin
                if (i_frame_start) begin
                    w_state_next = StIdle;
                    w_commit     = 1'b1;
                end else begin
                    w_capturing = 1'b1;
                    if (i_frame_end) begin
                        w_state_next = StIdle;
                        w_commit     = 1'b1;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_cand     = w_capturing & i_s_valid & i_s_flag;
    assign w_key      = {i_s_y, i_s_x};
    assign w_ptr_eff  = w_restart ? '0 : r_ptr;
    assign w_full     = (w_ptr_eff == PTR_MAX);
    assign w_ptr_next = w_ptr_eff + BAD_POINT_BIT'(w_write);

    badpoint_order_filter #(
        .KEY_BITS (KEY_BITS)
    ) u_order_filter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_restart),
        .i_cand      (w_cand),
        .i_key       (w_key),
        .i_full      (w_full),
        .o_write     (w_write),
        .o_order_err (w_order_hit),
        .o_overflow  (w_ovf_hit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_num       <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_order_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_wen       <= w_write;
            r_done      <= w_commit;
            r_overflow  <= (r_overflow & ~w_restart) | w_ovf_hit;
            r_order_err <= (r_order_err & ~w_restart) | w_order_hit;
            if (w_write) begin
                r_waddr <= w_ptr_eff;
                r_wdata <= pack_bad_xy(16'(i_s_y), 16'(i_s_x));
            end
            // Zero the count while the LUT is being rewritten so the checker stays idle
            if (w_restart) begin
                r_num <= '0;
            end else if (w_commit) begin
                r_num <= w_ptr_next;
            end
        end
    end

    assign o_wen_lut       = r_wen;
    assign o_waddr_lut     = r_waddr;
    assign o_wdata_lut     = r_wdata;
    assign o_bad_point_num = r_num;
    assign o_cal_busy      = (r_state != StIdle);
    assign o_cal_done      = r_done;
    assign o_overflow      = r_overflow;
    assign o_order_err     = r_order_err;

endmodule

// File: tb/tb_badpoint_lut_capture.sv
// Self-checking bench for badpoint_lut_capture: directed vector table, directed corner
// sequences and random frames scored against a list-based model of the LUT contents.
module tb_badpoint_lut_capture;

    localparam int NUM = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        cal_start, frame_start, frame_end, s_valid, s_flag;
    logic [9:0]  s_x, s_y;
    logic        wen_lut;
    logic [6:0]  waddr_lut;
    logic [31:0] wdata_lut;
    logic [6:0]  bad_point_num;
    logic        cal_busy, cal_done, overflow, order_err;

    always #5 clk = ~clk;

    badpoint_lut_capture #(
        .WIDTH_BITS    (10),
        .HEIGHT_BITS   (10),
        .BAD_POINT_NUM (NUM),
        .BAD_POINT_BIT (7)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_cal_start     (cal_start),
        .i_frame_start   (frame_start),
        .i_frame_end     (frame_end),
        .i_s_valid       (s_valid),
        .i_s_x           (s_x),
        .i_s_y           (s_y),
        .i_s_flag        (s_flag),
        .o_wen_lut       (wen_lut),
        .o_waddr_lut     (waddr_lut),
        .o_wdata_lut     (wdata_lut),
        .o_bad_point_num (bad_point_num),
        .o_cal_busy      (cal_busy),
        .o_cal_done      (cal_done),
        .o_overflow      (overflow),
        .o_order_err     (order_err)
    );

    typedef struct {
        int x;
        int y;
        bit flag;
    } pix_t;

    typedef struct {
        bit          fs;
        bit          fe;
        bit          flag;
        int          x;
        int          y;
        bit          ewen;
        int          eaddr;
        logic [31:0] edata;
        bit          edone;
        int          enum_;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    pix_t        pix_q[$];
    logic [31:0] got_q[$];
    int          got_addr_q[$];
    logic [31:0] exp_q[$];
    bit          exp_ovf, exp_oerr;
    int          done_cnt;
    bit          last_done;
    int          committed = 0;
    bit          prev_ovf = 0, prev_oerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; outputs sampled 1ns after the edge, inputs then idled
    task automatic drive_px(input bit fs, input bit fe, input bit v, input bit flag,
                            input int x, input int y);
        frame_start = fs;
        frame_end   = fe;
        s_valid     = v;
        s_flag      = flag;
        s_x         = 10'(x);
        s_y         = 10'(y);
        @(posedge clk);
        #1;
        if (wen_lut === 1'b1) begin
            got_q.push_back(wdata_lut);
            got_addr_q.push_back(int'(waddr_lut));
        end
        last_done = cal_done;
        if (cal_done === 1'b1) done_cnt++;
        cal_start   = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        s_valid     = 1'b0;
        s_flag      = 1'b0;
    endtask

    // Expected LUT: flagged keys kept only if strictly above the last kept key, up to NUM-1
    function automatic void compute_model();
        int  last;
        bit  have;
        int  k;
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_oerr = 1'b0;
        have     = 1'b0;
        last     = 0;
        foreach (pix_q[i]) begin
            if (pix_q[i].flag) begin
                k = pix_q[i].y * 1024 + pix_q[i].x;
                if (have && k < last) exp_oerr = 1'b1;
                else if (have && k == last) begin end
                else if (exp_q.size() == NUM - 1) exp_ovf = 1'b1;
                else begin
                    exp_q.push_back((32'(pix_q[i].y) << 16) | 32'(pix_q[i].x));
                    last = k;
                    have = 1'b1;
                end
            end
        end
    endfunction

    task automatic gen_frame(input int n);
        int k;
        int r;
        pix_t p;
        pix_q.delete();
        k = $urandom_range(0, 2000);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) k = (k > 10) ? k - $urandom_range(1, 10) : k;
            else if (r >= 3) k = k + $urandom_range(1, 3);
            p.x    = k % 1024;
            p.y    = k / 1024;
            p.flag = (r < 3) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            pix_q.push_back(p);
        end
        k = k + 1;
        p.x    = k % 1024;
        p.y    = k / 1024;
        p.flag = 1'b1;
        pix_q.push_back(p);
    endtask

    task automatic run_frame(input string tag, input bit arm, input bit expect_cap,
                             input bit gaps);
        int n;
        got_q.delete();
        got_addr_q.delete();
        done_cnt = 0;
        if (expect_cap) compute_model();
        else exp_q.delete();
        if (arm) begin
            cal_start = 1'b1;
            drive_px(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
            chk({tag, "_busy_armed"}, cal_busy, 1'b1);
        end
        n = pix_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) drive_px(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
            drive_px(i == 0, i == n - 1, 1'b1, pix_q[i].flag, pix_q[i].x, pix_q[i].y);
        end
        chk({tag, "_done_at_fe1"}, last_done, expect_cap);
        chk({tag, "_count"}, bad_point_num, expect_cap ? exp_q.size() : committed);
        drive_px(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk({tag, "_done_after"}, last_done, 1'b0);
        chk({tag, "_busy_after"}, cal_busy, 1'b0);
        chk({tag, "_done_pulses"}, done_cnt, expect_cap);
        chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_wdata"}, got_q[i], exp_q[i]);
            chk({tag, "_waddr"}, got_addr_q[i], i);
        end
        if (expect_cap) begin
            committed = exp_q.size();
            prev_ovf  = exp_ovf;
            prev_oerr = exp_oerr;
        end
        chk({tag, "_overflow"}, overflow, prev_ovf);
        chk({tag, "_order_err"}, order_err, prev_oerr);
    endtask

    vec_t vecs[7];
    pix_t p;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cal_start = 1'b0;
        frame_start = 1'b0;
        frame_end = 1'b0;
        s_valid = 1'b0;
        s_flag = 1'b0;
        s_x = '0;
        s_y = '0;
        drive_px(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        drive_px(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        rst = 1'b0;
        chk("reset_state", {wen_lut, waddr_lut, bad_point_num, cal_busy, cal_done,
                            overflow, order_err}, '0);
        chk("reset_wdata", wdata_lut, 32'h0);

        // Directed frame: flags at (3,0), (7,2), (0,5)
        vecs[0] = '{1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0};
        vecs[1] = '{0, 0, 1, 3, 0, 1, 0, 32'h0000_0003, 0, 0};
        vecs[2] = '{0, 0, 0, 5, 1, 0, 0, 32'h0, 0, 0};
        vecs[3] = '{0, 0, 1, 7, 2, 1, 1, 32'h0002_0007, 0, 0};
        vecs[4] = '{0, 0, 1, 0, 5, 1, 2, 32'h0005_0000, 0, 0};
        vecs[5] = '{0, 1, 0, 1, 5, 0, 0, 32'h0, 1, 3};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 3};
        cal_start = 1'b1;
        drive_px(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("t1_busy_armed", cal_busy, 1'b1);
        foreach (vecs[i]) begin
            drive_px(vecs[i].fs, vecs[i].fe, 1'b1, vecs[i].flag, vecs[i].x, vecs[i].y);
            chk($sformatf("t1_wen[%0d]", i), wen_lut, vecs[i].ewen);
            if (vecs[i].ewen) begin
                chk($sformatf("t1_waddr[%0d]", i), waddr_lut, vecs[i].eaddr);
                chk($sformatf("t1_wdata[%0d]", i), wdata_lut, vecs[i].edata);
            end
            chk($sformatf("t1_done[%0d]", i), cal_done, vecs[i].edone);
            chk($sformatf("t1_count[%0d]", i), bad_point_num, vecs[i].enum_);
        end
        committed = 3;

        // Duplicate coordinate, then a pixel below the last entry
        pix_q.delete();
        p = '{0, 4, 0}; pix_q.push_back(p);
        p = '{2, 4, 1}; pix_q.push_back(p);
        p = '{2, 4, 1}; pix_q.push_back(p);
        p = '{1, 4, 1}; pix_q.push_back(p);
        p = '{3, 4, 1}; pix_q.push_back(p);
        run_frame("t3", 1'b1, 1'b1, 1'b0);

        // 130 distinct flagged pixels against 127 usable entries
        pix_q.delete();
        for (int i = 0; i < 130; i++) begin
            p = '{i % 16, i / 16, 1};
            pix_q.push_back(p);
        end
        run_frame("t2", 1'b1, 1'b1, 1'b0);

        // Unarmed frame ignored; frame_end while armed ignored
        gen_frame(30);
        run_frame("t4_unarmed", 1'b0, 1'b0, 1'b0);
        cal_start = 1'b1;
        drive_px(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        drive_px(1'b0, 1'b1, 1'b1, 1'b1, 5, 5);
        chk("t4_busy_after_fe", cal_busy, 1'b1);
        chk("t4_no_done", cal_done, 1'b0);
        chk("t4_no_wen", wen_lut, 1'b0);
        gen_frame(25);
        run_frame("t4_armed", 1'b0, 1'b1, 1'b1);

        for (int f = 0; f < 6; f++) begin
            gen_frame($urandom_range(20, 80));
            run_frame($sformatf("rnd%0d", f), 1'b1, 1'b1, f[0]);
        end

        // Reset after five writes mid-frame
        got_q.delete();
        got_addr_q.delete();
        cal_start = 1'b1;
        drive_px(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 20 && got_q.size() < 5; i++) begin
            drive_px(i == 0, 1'b0, 1'b1, 1'b1, i, 1);
        end
        chk("t5_five_writes", got_q.size(), 5);
        rst = 1'b1;
        drive_px(1'b0, 1'b0, 1'b1, 1'b1, 40, 1);
        rst = 1'b0;
        chk("t5_reset_state", {wen_lut, waddr_lut, bad_point_num, cal_busy, cal_done,
                               overflow, order_err}, '0);
        chk("t5_reset_wdata", wdata_lut, 32'h0);
        committed = 0;
        prev_ovf  = 1'b0;
        prev_oerr = 1'b0;
        gen_frame(20);
        run_frame("t5_rearm", 1'b1, 1'b1, 1'b0);

        // frame_start during capture: early commit, that pixel skipped, no re-arm
        got_q.delete();
        got_addr_q.delete();
        cal_start = 1'b1;
        drive_px(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        drive_px(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        drive_px(1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
        drive_px(1'b1, 1'b0, 1'b1, 1'b1, 2, 0);
        chk("t6_no_wen_on_fs", wen_lut, 1'b0);
        chk("t6_early_done", cal_done, 1'b1);
        chk("t6_early_count", bad_point_num, 2);
        chk("t6_idle", cal_busy, 1'b0);
        chk("t6_writes", got_q.size(), 2);
        committed = 2;
        drive_px(1'b1, 1'b0, 1'b1, 1'b1, 5, 0);
        drive_px(1'b0, 1'b1, 1'b1, 1'b1, 6, 0);
        drive_px(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("t6_no_rearm_writes", got_q.size(), 2);
        chk("t6_no_rearm_count", bad_point_num, committed);
        chk("t6_no_rearm_busy", cal_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
